// File: rtl/sfp_init_seq_if.sv
// Status and control bundle between the SFP init sequencer and its surroundings.
// The slave modport is the sequencer side; the master drives link status and restart.
interface sfp_init_seq_if;
    logic       idelayctrl_ready_in;
    logic       gt_reset_done_in;
    logic       link_up_in;
    logic       restart_in;
    logic       gt_reset_out;
    logic       user_reset_out;
    logic       ready_out;
    logic       fault_out;
    logic [3:0] retry_cnt_out;
    logic [2:0] state_out;

    modport slave (
        input  idelayctrl_ready_in,
        input  gt_reset_done_in,
        input  link_up_in,
        input  restart_in,
        output gt_reset_out,
        output user_reset_out,
        output ready_out,
        output fault_out,
        output retry_cnt_out,
        output state_out
    );

    modport master (
        output idelayctrl_ready_in,
        output gt_reset_done_in,
        output link_up_in,
        output restart_in,
        input  gt_reset_out,
        input  user_reset_out,
        input  ready_out,
        input  fault_out,
        input  retry_cnt_out,
        input  state_out
    );
endinterface

// File: rtl/sfp_init_seq.sv
// SFP/transceiver bring-up sequencer: IDELAYCTRL wait, GT reset pulse, done/link wait with retry.
// Status inputs act 3 edges after they change; all outputs are registered alongside the state.
module sfp_init_seq #(
    parameter int GT_RST_CYCLES  = 100,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int MAX_RETRY      = 3
) (
    input  logic          clk,
    input  logic          rst_in,
    sfp_init_seq_if.slave sfp
);
    typedef enum logic [2:0] {
        WAIT_IDC  = 3'd0,
        GT_RST    = 3'd1,
        WAIT_DONE = 3'd2,
        WAIT_LINK = 3'd3,
        RUN       = 3'd4,
        FAULT     = 3'd5
    } state_t;

    localparam logic [23:0] GT_LOAD   = 24'(GT_RST_CYCLES);
    localparam logic [23:0] TO_LOAD   = 24'(TIMEOUT_CYCLES);
    localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRY);

    (* ASYNC_REG = "TRUE" *) logic [2:0] sync_meta;
    (* ASYNC_REG = "TRUE" *) logic [2:0] sync_q;
    logic        rst_hold;
    logic        ready_s;
    logic        done_s;
    logic        link_s;

    state_t      state;
    state_t      state_nxt;
    logic [23:0] cnt;
    logic [23:0] cnt_nxt;
    logic [3:0]  retry;
    logic [3:0]  retry_nxt;
    logic        attempt_fail;

    logic        gt_q;
    logic        ur_q;
    logic        rdy_q;
    logic        flt_q;
    logic        gt_nxt;
    logic        ur_nxt;
    logic        rdy_nxt;
    logic        flt_nxt;

    // bit 0: IDELAYCTRL ready, bit 1: GT reset done, bit 2: link up
    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            sync_meta <= '0;
            sync_q    <= '0;
        end else begin
            sync_meta <= {sfp.link_up_in, sfp.gt_reset_done_in, sfp.idelayctrl_ready_in};
            sync_q    <= sync_meta;
        end
    end

    assign ready_s = sync_q[0];
    assign done_s  = sync_q[1];
    assign link_s  = sync_q[2];

    // Holds the FSM for the first edge after reset release so it starts on the second.
    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            rst_hold <= 1'b1;
        end else begin
            rst_hold <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            state <= WAIT_IDC;
            cnt   <= '0;
            retry <= '0;
            gt_q  <= 1'b1;
            ur_q  <= 1'b1;
            rdy_q <= 1'b0;
            flt_q <= 1'b0;
        end else if (!rst_hold) begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            retry <= retry_nxt;
            gt_q  <= gt_nxt;
            ur_q  <= ur_nxt;
            rdy_q <= rdy_nxt;
            flt_q <= flt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = (cnt == 24'd0) ? 24'd0 : cnt - 24'd1;
        retry_nxt    = retry;
        attempt_fail = 1'b0;
        if (sfp.restart_in) begin
            state_nxt = WAIT_IDC;
            retry_nxt = 4'd0;
        end else if (!ready_s && state != WAIT_IDC && state != FAULT) begin
            state_nxt = WAIT_IDC;
        end else begin
            case (state)
                WAIT_IDC: begin
                    if (ready_s) begin
                        state_nxt = GT_RST;
                        cnt_nxt   = GT_LOAD;
                    end
                end
                GT_RST: begin
                    if (cnt <= 24'd1) begin
                        state_nxt = WAIT_DONE;
                        cnt_nxt   = TO_LOAD;
                    end
                end
                // The awaited input is checked before expiry so a same-cycle arrival wins.
                WAIT_DONE: begin
                    if (done_s) begin
                        state_nxt = WAIT_LINK;
                        cnt_nxt   = TO_LOAD;
                    end else if (cnt <= 24'd1) begin
                        attempt_fail = 1'b1;
                    end
                end
                WAIT_LINK: begin
                    if (link_s) begin
                        state_nxt = RUN;
                        retry_nxt = 4'd0;
                    end else if (cnt <= 24'd1) begin
                        attempt_fail = 1'b1;
                    end
                end
                RUN: begin
                    retry_nxt = 4'd0;
                    if (!link_s || !done_s) begin
                        state_nxt = GT_RST;
                        cnt_nxt   = GT_LOAD;
                    end
                end
                FAULT: begin
                    state_nxt = FAULT;
                end
                default: begin
                    state_nxt = WAIT_IDC;
                end
            endcase
            if (attempt_fail) begin
                if (retry == RETRY_MAX) begin
                    state_nxt = FAULT;
                end else begin
                    state_nxt = GT_RST;
                    cnt_nxt   = GT_LOAD;
                    retry_nxt = retry + 4'd1;
                end
            end
        end
    end

    // Decoded from the next state so outputs move on the same edge as the state.
    always_comb begin
        gt_nxt  = 1'b1;
        ur_nxt  = 1'b1;
        rdy_nxt = 1'b0;
        flt_nxt = 1'b0;
        case (state_nxt)
            WAIT_DONE, WAIT_LINK: begin
                gt_nxt = 1'b0;
            end
            RUN: begin
                gt_nxt  = 1'b0;
                ur_nxt  = 1'b0;
                rdy_nxt = 1'b1;
            end
            FAULT: begin
                flt_nxt = 1'b1;
            end
            default: begin
                gt_nxt = 1'b1;
            end
        endcase
    end

    assign sfp.gt_reset_out   = gt_q;
    assign sfp.user_reset_out = ur_q;
    assign sfp.ready_out      = rdy_q;
    assign sfp.fault_out      = flt_q;
    assign sfp.retry_cnt_out  = retry;
    assign sfp.state_out      = state;
endmodule
